// File: rtl/rob_ring_pkg.sv
// Shared definitions for the reorder-buffer ring: default sizing, the
// recovery-action encoding and modular ring-pointer helpers.
package rob_ring_pkg;

    localparam int unsigned ROB_DEPTH_DEF = 16;
    localparam int unsigned PREG_W_DEF    = 6;
    localparam int unsigned N_RETIRE_DEF  = 2;

    // What the ring does with its contents this cycle on a mispredict
    typedef enum logic [1:0] {
        RECOV_NONE   = 2'd0,
        RECOV_SQUASH = 2'd1,
        RECOV_FLUSH  = 2'd2
    } recov_e;

    // (a + b) mod depth, assuming a < depth and b <= depth
    function automatic int unsigned ring_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned depth);
        int unsigned s;
        s = a + b;
        if (s >= depth) begin
            return s - depth;
        end else begin
            return s;
        end
    endfunction

    // Distance walking forward from 'from' to 'to' around the ring
    function automatic int unsigned ring_dist(input int unsigned from,
                                              input int unsigned to,
                                              input int unsigned depth);
        if (to >= from) begin
            return to - from;
        end else begin
            return to + depth - from;
        end
    endfunction

endpackage

// File: rtl/rob_ring_if.sv
// Dispatch / CDB / recovery / retire bundle of the reorder buffer.
// slave = the ROB itself, master = whoever drives dispatch and recovery.
interface rob_ring_if
    import rob_ring_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned PREG_W    = PREG_W_DEF,
    parameter int unsigned N_RETIRE  = N_RETIRE_DEF
);
    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = $clog2(ROB_DEPTH + 1);

    logic                         dispatch_en;
    logic [PREG_W-1:0]            T_new_in;
    logic [PREG_W-1:0]            T_old_in;
    logic [IDX_W-1:0]             dispatch_idx;
    logic                         CDB_en;
    logic [PREG_W-1:0]            CDB_tag;
    logic                         branch_mispredict;
    logic [IDX_W-1:0]             branch_rob_idx;
    logic [N_RETIRE-1:0]          retire_valid;
    logic [N_RETIRE*PREG_W-1:0]   T_free;
    logic [N_RETIRE*PREG_W-1:0]   T_arch;
    logic                         rob_full;
    logic                         rob_empty;
    logic [CNT_W-1:0]             rob_free_entries;

    modport slave (
        input  dispatch_en, T_new_in, T_old_in, CDB_en, CDB_tag,
               branch_mispredict, branch_rob_idx,
        output dispatch_idx, retire_valid, T_free, T_arch,
               rob_full, rob_empty, rob_free_entries
    );

    modport master (
        output dispatch_en, T_new_in, T_old_in, CDB_en, CDB_tag,
               branch_mispredict, branch_rob_idx,
        input  dispatch_idx, retire_valid, T_free, T_arch,
               rob_full, rob_empty, rob_free_entries
    );

endinterface

// File: rtl/rob_tag_cam.sv
// CDB tag match across all ROB entries. Only valid entries can hit, so an
// empty slot holding a stale tag never gets marked complete.
module rob_tag_cam #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned PREG_W    = 6
) (
    input  logic                          cdb_en,
    input  logic [PREG_W-1:0]             cdb_tag,
    input  logic [ROB_DEPTH-1:0]          entry_valid,
    input  logic [ROB_DEPTH*PREG_W-1:0]   entry_tag,
    output logic [ROB_DEPTH-1:0]          hit
);

    // One comparator per entry, qualified by broadcast-valid and entry-valid
    always_comb begin
        hit = {ROB_DEPTH{1'b0}};
        for (int i = 0; i < ROB_DEPTH; i++) begin
            hit[i] = cdb_en & entry_valid[i] &
                     (entry_tag[i*PREG_W +: PREG_W] == cdb_tag);
        end
    end

endmodule

// File: rtl/rob_ring.sv
// Reorder buffer: circular queue with head/tail/count, CDB completion via a
// tag CAM, and in-order retire of up to N_RETIRE entries per cycle.
// Build option ROB_BRANCH_SQUASH_EN: a mispredict squashes only entries
// younger than the branch. Without it a mispredict flushes the whole ring.
module rob_ring
    import rob_ring_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned PREG_W    = PREG_W_DEF,
    parameter int unsigned N_RETIRE  = N_RETIRE_DEF
) (
    input  logic       clock,
    input  logic       reset,
    rob_ring_if.slave  rob
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = $clog2(ROB_DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [PREG_W-1:0] t_new;
        logic [PREG_W-1:0] t_old;
    } rob_entry_t;

    rob_entry_t                 entry_q [ROB_DEPTH];
    rob_entry_t                 entry_d [ROB_DEPTH];
    logic [IDX_W-1:0]           head_q, head_d;
    logic [IDX_W-1:0]           tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic                       full_s;
    logic                       empty_s;
    logic [CNT_W-1:0]           free_s;
    logic                       disp_s;
    recov_e                     recov_s;
    int unsigned                br_dist_s;
    logic [ROB_DEPTH-1:0]       cam_valid_s;
    logic [ROB_DEPTH*PREG_W-1:0] cam_tag_s;
    logic [ROB_DEPTH-1:0]       cam_hit_s;
    logic [IDX_W-1:0]           lane_idx_s [N_RETIRE];
    logic [N_RETIRE-1:0]        ret_lane_s;
    logic [CNT_W-1:0]           nret_s;
    logic [ROB_DEPTH-1:0]       ret_mask_s;
    logic [N_RETIRE*PREG_W-1:0] t_free_s;
    logic [N_RETIRE*PREG_W-1:0] t_arch_s;

    // Occupancy flags straight from the registered count
    always_comb begin
        full_s  = (count_q == CNT_W'(ROB_DEPTH));
        empty_s = (count_q == CNT_W'(0));
        free_s  = CNT_W'(ROB_DEPTH) - count_q;
        disp_s  = rob.dispatch_en & ~full_s & ~rob.branch_mispredict;
    end

    // Decide the recovery action and how far the branch sits from head
    always_comb begin
        br_dist_s = ring_dist(32'(head_q), 32'(rob.branch_rob_idx), ROB_DEPTH);
        if (rob.branch_mispredict) begin
`ifdef ROB_BRANCH_SQUASH_EN
            recov_s = RECOV_SQUASH;
`else
            recov_s = RECOV_FLUSH;
`endif
        end else begin
            recov_s = RECOV_NONE;
        end
    end

    // Present the entry array to the tag CAM
    always_comb begin
        cam_valid_s = {ROB_DEPTH{1'b0}};
        cam_tag_s   = {(ROB_DEPTH*PREG_W){1'b0}};
        for (int i = 0; i < ROB_DEPTH; i++) begin
            cam_valid_s[i]                   = entry_q[i].valid;
            cam_tag_s[i*PREG_W +: PREG_W]    = entry_q[i].t_new;
        end
    end

    rob_tag_cam #(
        .ROB_DEPTH (ROB_DEPTH),
        .PREG_W    (PREG_W)
    ) u_cam (
        .cdb_en      (rob.CDB_en),
        .cdb_tag     (rob.CDB_tag),
        .entry_valid (cam_valid_s),
        .entry_tag   (cam_tag_s),
        .hit         (cam_hit_s)
    );

    // Ring index examined by each retire lane
    always_comb begin
        for (int k = 0; k < N_RETIRE; k++) begin
            lane_idx_s[k] = IDX_W'(ring_add(32'(head_q), k, ROB_DEPTH));
        end
    end

    // In-order retire scan: a lane fires only if it and every older lane are
    // valid and ready; squashed-away lanes and flush/reset cycles never fire
    always_comb begin
        logic chain_v;
        chain_v    = 1'b1;
        nret_s     = CNT_W'(0);
        ret_lane_s = {N_RETIRE{1'b0}};
        t_free_s   = {(N_RETIRE*PREG_W){1'b1}};
        t_arch_s   = {(N_RETIRE*PREG_W){1'b1}};
        for (int k = 0; k < N_RETIRE; k++) begin
            chain_v = chain_v & entry_q[lane_idx_s[k]].valid &
                      entry_q[lane_idx_s[k]].ready;
            case (recov_s)
                RECOV_NONE:   chain_v = chain_v;
                RECOV_SQUASH: chain_v = chain_v & (32'(k) <= br_dist_s);
                RECOV_FLUSH:  chain_v = 1'b0;
                default:      chain_v = 1'b0;
            endcase
            if (reset) begin
                chain_v = 1'b0;
            end else begin
                chain_v = chain_v;
            end
            ret_lane_s[k] = chain_v;
            if (chain_v) begin
                nret_s                        = nret_s + CNT_W'(1);
                t_free_s[k*PREG_W +: PREG_W]  = entry_q[lane_idx_s[k]].t_old;
                t_arch_s[k*PREG_W +: PREG_W]  = entry_q[lane_idx_s[k]].t_new;
            end else begin
                t_free_s[k*PREG_W +: PREG_W]  = {PREG_W{1'b1}};
                t_arch_s[k*PREG_W +: PREG_W]  = {PREG_W{1'b1}};
            end
        end
    end

    // Per-entry mask of slots leaving the ring through retire this cycle
    always_comb begin
        ret_mask_s = {ROB_DEPTH{1'b0}};
        for (int k = 0; k < N_RETIRE; k++) begin
            ret_mask_s[lane_idx_s[k]] = ret_mask_s[lane_idx_s[k]] | ret_lane_s[k];
        end
    end

    // Next ring state: complete, retire, then dispatch or recover
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            entry_d[i]       = entry_q[i];
            entry_d[i].valid = entry_q[i].valid & ~ret_mask_s[i];
            entry_d[i].ready = (entry_q[i].ready | cam_hit_s[i]) & ~ret_mask_s[i];
        end
        head_d  = IDX_W'(ring_add(32'(head_q), 32'(nret_s), ROB_DEPTH));
        tail_d  = tail_q;
        count_d = count_q;
        case (recov_s)
            RECOV_NONE: begin
                if (disp_s) begin
                    entry_d[tail_q] = '{valid: 1'b1, ready: 1'b0,
                                        t_new: rob.T_new_in, t_old: rob.T_old_in};
                    tail_d = IDX_W'(ring_add(32'(tail_q), 32'd1, ROB_DEPTH));
                end else begin
                    tail_d = tail_q;
                end
                count_d = count_q + CNT_W'(disp_s) - nret_s;
            end
            RECOV_SQUASH: begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (ring_dist(32'(head_q), i, ROB_DEPTH) > br_dist_s) begin
                        entry_d[i].valid = 1'b0;
                        entry_d[i].ready = 1'b0;
                    end else begin
                        entry_d[i].valid = entry_d[i].valid;
                    end
                end
                tail_d  = IDX_W'(ring_add(32'(rob.branch_rob_idx), 32'd1, ROB_DEPTH));
                count_d = CNT_W'(br_dist_s + 32'd1) - nret_s;
            end
            RECOV_FLUSH: begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entry_d[i] = '0;
                end
                head_d  = IDX_W'(0);
                tail_d  = IDX_W'(0);
                count_d = CNT_W'(0);
            end
            default: begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entry_d[i] = '0;
                end
                head_d  = IDX_W'(0);
                tail_d  = IDX_W'(0);
                count_d = CNT_W'(0);
            end
        endcase
    end

    // Ring state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= IDX_W'(0);
            tail_q  <= IDX_W'(0);
            count_q <= CNT_W'(0);
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign rob.dispatch_idx     = tail_q;
    assign rob.retire_valid     = ret_lane_s;
    assign rob.T_free           = t_free_s;
    assign rob.T_arch           = t_arch_s;
    assign rob.rob_full         = full_s;
    assign rob.rob_empty        = empty_s;
    assign rob.rob_free_entries = free_s;

endmodule

// File: tb/tb_rob_ring.sv
// Self-checking bench for rob_ring: an age-ordered queue model predicts
// occupancy and retire width each cycle; retired {T_old,T_new} pairs go to a
// scoreboard that a negedge monitor drains against the retire lanes.
module tb_rob_ring;

    localparam int D  = 16;
    localparam int PW = 6;
    localparam int NR = 2;

    typedef struct {
        logic [PW-1:0] t_new;
        logic [PW-1:0] t_old;
        bit            ready;
    } ment_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mon_en;

    ment_t              mq[$];       // in-flight entries, oldest first
    int                 head_m;
    logic [2*PW-1:0]    exp_ret[$];  // {t_old, t_new} expected on retire lanes

    rob_ring_if #(.ROB_DEPTH(D), .PREG_W(PW), .N_RETIRE(NR)) bif ();

    rob_ring #(.ROB_DEPTH(D), .PREG_W(PW), .N_RETIRE(NR)) dut (
        .clock (clk),
        .reset (rst),
        .rob   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every firing lane must match the next expected retire
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NR; k++) begin
                if (bif.retire_valid[k]) begin
                    if (exp_ret.size() == 0) begin
                        chk("retire_unexpected", k, -1);
                    end else begin
                        logic [2*PW-1:0] e;
                        e = exp_ret.pop_front();
                        chk("T_free", int'(bif.T_free[k*PW +: PW]), int'(e[2*PW-1:PW]));
                        chk("T_arch", int'(bif.T_arch[k*PW +: PW]), int'(e[PW-1:0]));
                    end
                end else begin
                    chk("T_free_idle", int'(bif.T_free[k*PW +: PW]), (1 << PW) - 1);
                    chk("T_arch_idle", int'(bif.T_arch[k*PW +: PW]), (1 << PW) - 1);
                end
            end
        end
    end

    // One clock of stimulus: predict, update model, check at negedge
    task automatic step(input bit de, input logic [PW-1:0] tn, input logic [PW-1:0] to,
                        input bit ce, input logic [PW-1:0] ct,
                        input bit mp, input int bj, input bit rs);
        int cnt;
        int nexp;
        bit e_full;
        int e_didx;
        cnt    = mq.size();
        e_full = (cnt == D);
        e_didx = (head_m + cnt) % D;

        bif.dispatch_en       = de;
        bif.T_new_in          = tn;
        bif.T_old_in          = to;
        bif.CDB_en            = ce;
        bif.CDB_tag           = ct;
        bif.branch_mispredict = mp;
        bif.branch_rob_idx    = 4'((head_m + bj) % D);
        rst                   = rs;

        nexp = 0;
        for (int j = 0; j < NR && j < cnt; j++) begin
            if (mq[j].ready && nexp == j) nexp++;
        end
        if (rs) nexp = 0;
`ifdef ROB_BRANCH_SQUASH_EN
        if (mp && nexp > bj + 1) nexp = bj + 1;
`else
        if (mp) nexp = 0;
`endif
        for (int j = 0; j < nexp; j++) exp_ret.push_back({mq[j].t_old, mq[j].t_new});

        if (rs) begin
            mq.delete();
            head_m = 0;
        end else begin
            if (ce) begin
                foreach (mq[j]) if (mq[j].t_new == ct) mq[j].ready = 1'b1;
            end
`ifdef ROB_BRANCH_SQUASH_EN
            if (mp) while (mq.size() > bj + 1) void'(mq.pop_back());
`else
            if (mp) begin
                mq.delete();
                head_m = 0;
            end
`endif
            for (int j = 0; j < nexp; j++) void'(mq.pop_front());
            head_m = (head_m + nexp) % D;
            if (de && !e_full && !mp) mq.push_back('{t_new: tn, t_old: to, ready: 1'b0});
        end

        @(negedge clk);
        chk("rob_full", int'(bif.rob_full), int'(e_full));
        chk("rob_empty", int'(bif.rob_empty), int'(cnt == 0));
        chk("rob_free_entries", int'(bif.rob_free_entries), D - cnt);
        chk("dispatch_idx", int'(bif.dispatch_idx), e_didx);
        chk("retire_valid", int'(bif.retire_valid), (1 << nexp) - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 0);
    endtask

    // Complete the oldest not-ready entry each cycle until the ring drains
    task automatic drain();
        for (int it = 0; it < 200; it++) begin
            int sel;
            if (mq.size() == 0) break;
            sel = -1;
            foreach (mq[j]) if (sel < 0 && !mq[j].ready) sel = j;
            if (sel < 0) step(0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 0);
            else step(0, 6'd0, 6'd0, 1, mq[sel].t_new, 0, 0, 0);
        end
        idle(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        head_m = 0;
        rst = 1'b1;
        bif.dispatch_en = 1'b0;
        bif.T_new_in = '0;
        bif.T_old_in = '0;
        bif.CDB_en = 1'b0;
        bif.CDB_tag = '0;
        bif.branch_mispredict = 1'b0;
        bif.branch_rob_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset state, then dispatch 5/1 and complete it
        idle(1);
        step(1, 6'd5, 6'd1, 0, 6'd0, 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd5, 0, 0, 0);
        idle(2);

        // Fill to full, extra dispatch ignored, out-of-order completion
        for (int i = 0; i < D; i++) step(1, 6'(10 + i), 6'(i), 0, 6'd0, 0, 0, 0);
        step(1, 6'd60, 6'd61, 0, 6'd0, 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd11, 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd12, 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd10, 0, 0, 0);
        idle(2);
        drain();

        // Move head to 14, then dispatch across the wrap point
        step(0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 1);
        for (int i = 0; i < 14; i++) step(1, 6'(i + 1), 6'(i), i > 0, 6'(i), 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd14, 0, 0, 0);
        idle(8);
        for (int i = 0; i < 4; i++) step(1, 6'(40 + i), 6'(50 + i), 0, 6'd0, 0, 0, 0);
        drain();

        // Mispredict on the third of six entries
        step(0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 6'(20 + i), 6'(30 + i), 0, 6'd0, 0, 0, 0);
        step(1, 6'd33, 6'd34, 0, 6'd0, 1, 2, 0);
        idle(1);
        drain();

        // Reset while eight entries are valid and ready
        for (int i = 0; i < 8; i++) step(1, 6'd7, 6'(i), 0, 6'd0, 0, 0, 0);
        step(0, 6'd0, 6'd0, 1, 6'd7, 0, 0, 0);
        step(0, 6'd0, 6'd0, 0, 6'd0, 0, 0, 1);
        idle(2);

        // Randomised traffic
        for (int it = 0; it < 1500; it++) begin
            bit de, ce, mp, rs;
            logic [PW-1:0] ct;
            int bj;
            de = ($urandom_range(0, 9) < 6);
            ce = ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                ct = mq[$urandom_range(0, mq.size() - 1)].t_new;
            else
                ct = 6'($urandom);
            mp = (mq.size() > 0) && ($urandom_range(0, 49) == 0);
            bj = mp ? int'($urandom_range(0, mq.size() - 1)) : 0;
            rs = ($urandom_range(0, 199) == 0);
            step(de, 6'($urandom), 6'($urandom), ce, ct, mp, bj, rs);
        end
        drain();
        chk("scoreboard_leftover", exp_ret.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
